rdlvl_resp_agg: RTL and testbench
=================================

RDLVL_RESP_AGG -- requirements
Module: rdlvl_resp_agg

Interface
REQ-001 SHALL have parameter IOG_DQS_LANES, default 9, number of DQS lanes (1..9).
REQ-002 SHALL have port SCLK  input  1  system clock; all logic on its rising edge.
REQ-003 SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port dfi_rdlvl_en  input  1  read-level (data eye) request from NWL controller.
REQ-005 SHALL have port dfi_rdlvl_gate_en  input  1  read-gate training request from NWL controller.
REQ-006 SHALL have port dfi_rdlvl_resp_internal  input  IOG_DQS_LANES  per-lane training-done level.
REQ-007 SHALL have port rd_training_error  input  IOG_DQS_LANES  per-lane error, valid in any cycle while training.
REQ-008 SHALL have port lane_mask  input  IOG_DQS_LANES  1 = lane participates; sampled at training start.
REQ-009 SHALL have port timeout_cycles  input  16  timeout limit in SCLK cycles; 0 = timeout disabled.
REQ-010 SHALL have port dfi_rdlvl_resp  output  1  aggregated training response to NWL.
REQ-011 SHALL have port rdlvl_error  output  1  any masked-in lane reported an error.
REQ-012 SHALL have port rdlvl_timeout  output  1  the last training ended by timeout.
REQ-013 SHALL have port rdlvl_gate_mode  output  1  1 = the last training was gate training.
REQ-014 SHALL have port lane_done_status  output  IOG_DQS_LANES  sticky per-lane done.
REQ-015 SHALL have port lane_err_status  output  IOG_DQS_LANES  sticky per-lane error.
REQ-016 SHALL have port train_cycles  output  16  cycles spent in TRAIN, saturating.

Function
REQ-017 SHALL implement FSM states IDLE, TRAIN, RESP, WAIT_DEASSERT.
REQ-018 IDLE -> TRAIN SHALL occur on the first cycle req = dfi_rdlvl_en | dfi_rdlvl_gate_en is high; latch lane_mask and rdlvl_gate_mode = dfi_rdlvl_gate_en; clear lane_done_status, lane_err_status, train_cycles, rdlvl_error, rdlvl_timeout.
REQ-019 In TRAIN, lane_done_status[i] SHALL set when dfi_rdlvl_resp_internal[i]=1; lane_err_status[i] SHALL set when rd_training_error[i]=1; both sticky until the next start.
REQ-020 In TRAIN, train_cycles SHALL increment each cycle and saturate at 16'hFFFF.
REQ-021 TRAIN -> RESP SHALL occur when (lane_done_status_next | ~latched_mask) is all ones; dfi_rdlvl_resp rises on the next edge (1-cycle latency from the last lane's resp sample).
REQ-022 TRAIN -> RESP with rdlvl_timeout=1 SHALL occur when timeout_cycles!=0 and train_cycles==timeout_cycles-1 in the current cycle.
REQ-023 When completion and timeout occur in the same cycle, completion SHALL win and rdlvl_timeout SHALL stay 0.
REQ-024 On entry to RESP, rdlvl_error SHALL equal |(lane_err_status_next & latched_mask).
REQ-025 dfi_rdlvl_resp SHALL be 1 only in RESP; RESP SHALL hold until req=0, then go to IDLE.
REQ-026 If req falls while in TRAIN (abort), the FSM SHALL go to IDLE without asserting dfi_rdlvl_resp; status SHALL be retained.
REQ-027 With latched_mask all zero, the FSM SHALL enter RESP one cycle after entering TRAIN.
REQ-028 After RESP exit, re-entry to TRAIN SHALL require req low for at least 1 cycle (WAIT_DEASSERT absorbs a same-cycle re-assert).
REQ-029 Lane inputs SHALL be ignored outside TRAIN.

Reset
REQ-030 While reset_n=0, the FSM SHALL be IDLE and every output and status register SHALL be 0, independent of SCLK.
REQ-031 Reset assertion mid-TRAIN or mid-RESP SHALL drop dfi_rdlvl_resp immediately; after release, the block SHALL start only on a new req.

Structure
REQ-032 A shared package SHALL hold the FSM state encoding (2-bit), MAX_DQS_LANES=9 and the counter width 16.
REQ-033 Per-lane sticky done/error logic SHALL be one sub-module, rdlvl_lane_status, instantiated IOG_DQS_LANES times in a generate loop.

Verification
REQ-034 Lanes=9, mask=9'h1FF, timeout=0; dfi_rdlvl_en=1; lane resps at cycles 10..18 -> dfi_rdlvl_resp=1 at cycle 19, train_cycles=9, error=0.
REQ-035 mask=9'h0FF, lane 8 never responds, lane 3 error pulse at cycle 5 -> resp after lane 7, lane_err_status=9'h008, rdlvl_error=1.
REQ-036 timeout=100, lane 2 never done -> resp at cycle 101, rdlvl_timeout=1, lane_done_status=9'h1FB.
REQ-037 Last lane done in the same cycle timeout expires -> resp=1, rdlvl_timeout=0.
REQ-038 dfi_rdlvl_gate_en start then req dropped at cycle 4 -> no resp, FSM IDLE, rdlvl_gate_mode=1; reset_n pulsed during RESP -> resp=0 asynchronously and all status=0.

Source files
------------

// File: rtl/rdlvl_resp_agg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rdlvl_resp_agg_pkg
// Brief    : Shared constants, FSM encoding and helpers for read-level
//            response aggregation.
// Revision : 1.0 - initial release
// ============================================================================
package rdlvl_resp_agg_pkg;

    localparam int MAX_DQS_LANES = 9;
    localparam int CNT_W         = 16;

    typedef enum logic [1:0] {
        ST_IDLE          = 2'd0,
        ST_TRAIN         = 2'd1,
        ST_RESP          = 2'd2,
        ST_WAIT_DEASSERT = 2'd3
    } state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        return (&value) ? value : value + CNT_W'(1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rdlvl_lane_status.sv
`default_nettype none
// ============================================================================
// Module   : rdlvl_lane_status
// Brief    : Sticky done/error flags for one DQS lane during read training.
// Revision : 1.0 - initial release
// ============================================================================
module rdlvl_lane_status (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_enable,
    input  logic i_resp,
    input  logic i_err,
    output logic o_done,
    output logic o_err,
    output logic o_done_next,
    output logic o_err_next
);

    logic r_done;
    logic r_err;
    logic w_done_next;
    logic w_err_next;

    // The next-state values are exported so the aggregator can decide
    // completion in the same cycle the last lane reports.
    assign w_done_next = i_clear ? 1'b0 : (r_done | (i_enable & i_resp));
    assign w_err_next  = i_clear ? 1'b0 : (r_err  | (i_enable & i_err));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_done <= w_done_next;
            r_err  <= w_err_next;
        end
    end

    assign o_done      = r_done;
    assign o_err       = r_err;
    assign o_done_next = w_done_next;
    assign o_err_next  = w_err_next;

endmodule
`default_nettype wire

// File: rtl/rdlvl_resp_agg.sv
`default_nettype none
// ============================================================================
// Module   : rdlvl_resp_agg
// Brief    : Aggregates per-lane read-level / read-gate training responses
//            into a single DFI response with error, timeout and status.
// Revision : 1.0 - initial release
// ============================================================================
module rdlvl_resp_agg
    import rdlvl_resp_agg_pkg::*;
#(
    parameter int IOG_DQS_LANES = 9
) (
    input  logic                     SCLK,
    input  logic                     reset_n,
    input  logic                     dfi_rdlvl_en,
    input  logic                     dfi_rdlvl_gate_en,
    input  logic [IOG_DQS_LANES-1:0] dfi_rdlvl_resp_internal,
    input  logic [IOG_DQS_LANES-1:0] rd_training_error,
    input  logic [IOG_DQS_LANES-1:0] lane_mask,
    input  logic [CNT_W-1:0]         timeout_cycles,
    output logic                     dfi_rdlvl_resp,
    output logic                     rdlvl_error,
    output logic                     rdlvl_timeout,
    output logic                     rdlvl_gate_mode,
    output logic [IOG_DQS_LANES-1:0] lane_done_status,
    output logic [IOG_DQS_LANES-1:0] lane_err_status,
    output logic [CNT_W-1:0]         train_cycles
);

    state_t                   r_state;
    state_t                   w_state_next;
    logic [IOG_DQS_LANES-1:0] r_mask;
    logic [IOG_DQS_LANES-1:0] w_done_next;
    logic [IOG_DQS_LANES-1:0] w_err_next;
    logic [CNT_W-1:0]         r_train_cycles;
    logic                     r_gate_mode;
    logic                     r_error;
    logic                     r_timeout;
    logic                     w_req;
    logic                     w_start;
    logic                     w_in_train;
    logic                     w_complete;
    logic                     w_expire;

    assign w_req      = dfi_rdlvl_en | dfi_rdlvl_gate_en;
    assign w_start    = (r_state == ST_IDLE) & w_req;
    assign w_in_train = (r_state == ST_TRAIN);
    assign w_complete = &(w_done_next | ~r_mask);
    assign w_expire   = (timeout_cycles != '0) &&
                        (r_train_cycles == (timeout_cycles - CNT_W'(1)));

    generate
        for (genvar i = 0; i < IOG_DQS_LANES; i++) begin : g_lane
            rdlvl_lane_status u_lane_status (
                .clk         (SCLK),
                .rst_n       (reset_n),
                .i_clear     (w_start),
                .i_enable    (w_in_train),
                .i_resp      (dfi_rdlvl_resp_internal[i]),
                .i_err       (rd_training_error[i]),
                .o_done      (lane_done_status[i]),
                .o_err       (lane_err_status[i]),
                .o_done_next (w_done_next[i]),
                .o_err_next  (w_err_next[i])
            );
        end
    endgenerate

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_req) w_state_next = ST_TRAIN;
            end
            ST_TRAIN: begin
                if (!w_req)                      w_state_next = ST_IDLE;
                else if (w_complete || w_expire) w_state_next = ST_RESP;
            end
            ST_RESP: begin
                if (!w_req) w_state_next = ST_WAIT_DEASSERT;
            end
            // One dead cycle so a request re-raised right after the drop
            // cannot start a new training back-to-back.
            ST_WAIT_DEASSERT: w_state_next = ST_IDLE;
            default:          w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge SCLK or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= ST_IDLE;
            r_mask         <= '0;
            r_train_cycles <= '0;
            r_gate_mode    <= 1'b0;
            r_error        <= 1'b0;
            r_timeout      <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_start) begin
                r_mask         <= lane_mask;
                r_gate_mode    <= dfi_rdlvl_gate_en;
                r_train_cycles <= '0;
                r_error        <= 1'b0;
                r_timeout      <= 1'b0;
            end else if (w_in_train) begin
                r_train_cycles <= sat_inc(r_train_cycles);
                if (w_req && (w_complete || w_expire)) begin
                    r_error   <= |(w_err_next & r_mask);
                    r_timeout <= ~w_complete;
                end
            end
        end
    end

    assign dfi_rdlvl_resp  = (r_state == ST_RESP);
    assign rdlvl_error     = r_error;
    assign rdlvl_timeout   = r_timeout;
    assign rdlvl_gate_mode = r_gate_mode;
    assign train_cycles    = r_train_cycles;

endmodule
`default_nettype wire

// File: tb/tb_rdlvl_resp_agg.sv
`default_nettype none
// ============================================================================
// Module   : tb_rdlvl_resp_agg
// Brief    : Self-checking bench for rdlvl_resp_agg (table, random, corners).
// Revision : 1.0 - initial release
// ============================================================================
module tb_rdlvl_resp_agg;

    localparam int         LANES = 9;
    localparam logic [7:0] NEVER = 8'hFF;

    typedef logic [LANES-1:0][7:0] lanes_t;

    typedef struct {
        logic [8:0]  mask;
        logic [15:0] tmo;
        logic        gate;
        lanes_t      done_at;
        lanes_t      err_at;
        int          lat;
        int          tc;
        logic        to;
        logic        er;
        logic [8:0]  dn;
        logic [8:0]  es;
    } vec_t;

    logic             SCLK = 1'b0;
    logic             reset_n = 1'b1;
    logic             dfi_rdlvl_en = 1'b0;
    logic             dfi_rdlvl_gate_en = 1'b0;
    logic [LANES-1:0] dfi_rdlvl_resp_internal = '0;
    logic [LANES-1:0] rd_training_error = '0;
    logic [LANES-1:0] lane_mask = '0;
    logic [15:0]      timeout_cycles = '0;
    logic             dfi_rdlvl_resp;
    logic             rdlvl_error;
    logic             rdlvl_timeout;
    logic             rdlvl_gate_mode;
    logic [LANES-1:0] lane_done_status;
    logic [LANES-1:0] lane_err_status;
    logic [15:0]      train_cycles;

    int checks = 0;
    int errors = 0;

    rdlvl_resp_agg #(.IOG_DQS_LANES(LANES)) dut (
        .SCLK                    (SCLK),
        .reset_n                 (reset_n),
        .dfi_rdlvl_en            (dfi_rdlvl_en),
        .dfi_rdlvl_gate_en       (dfi_rdlvl_gate_en),
        .dfi_rdlvl_resp_internal (dfi_rdlvl_resp_internal),
        .rd_training_error       (rd_training_error),
        .lane_mask               (lane_mask),
        .timeout_cycles          (timeout_cycles),
        .dfi_rdlvl_resp          (dfi_rdlvl_resp),
        .rdlvl_error             (rdlvl_error),
        .rdlvl_timeout           (rdlvl_timeout),
        .rdlvl_gate_mode         (rdlvl_gate_mode),
        .lane_done_status        (lane_done_status),
        .lane_err_status         (lane_err_status),
        .train_cycles            (train_cycles)
    );

    always #5 SCLK = ~SCLK;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic lanes_t stair();
        lanes_t l;
        for (int i = 0; i < LANES; i++) l[i] = 8'(i);
        return l;
    endfunction

    function automatic lanes_t all_at(input logic [7:0] v);
        lanes_t l;
        for (int i = 0; i < LANES; i++) l[i] = v;
        return l;
    endfunction

    // Reference: training ends in the first cycle all masked lanes have
    // reported, or in cycle tmo-1 if that comes strictly earlier.
    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        int kc = 0;
        int m;
        for (int i = 0; i < LANES; i++)
            if (v.mask[i]) kc = (v.done_at[i] == NEVER) ? 100000 :
                                ((int'(v.done_at[i]) > kc) ? int'(v.done_at[i]) : kc);
        if (v.tmo != 0 && int'(v.tmo) - 1 < kc) begin
            m = int'(v.tmo) - 1;
            r.to = 1'b1;
        end else begin
            m = kc;
            r.to = 1'b0;
        end
        for (int i = 0; i < LANES; i++) begin
            r.dn[i] = (v.done_at[i] != NEVER) && (int'(v.done_at[i]) <= m);
            r.es[i] = (v.err_at[i] != NEVER) && (int'(v.err_at[i]) <= m);
        end
        r.er  = |(r.es & v.mask);
        r.lat = m + 1;
        r.tc  = m + 1;
        return r;
    endfunction

    task automatic drive_lanes(input vec_t v, input int k);
        for (int i = 0; i < LANES; i++) begin
            dfi_rdlvl_resp_internal[i] = (v.done_at[i] != NEVER) && (k >= int'(v.done_at[i]));
            rd_training_error[i]       = (v.err_at[i] != NEVER) && (k == int'(v.err_at[i]));
        end
    endtask

    task automatic run_ep(input vec_t v, input string nm);
        int lat = 0;
        bit got = 0;
        @(negedge SCLK);
        lane_mask         = v.mask;
        timeout_cycles    = v.tmo;
        dfi_rdlvl_gate_en = v.gate;
        dfi_rdlvl_en      = ~v.gate;
        @(posedge SCLK);
        for (int k = 0; k < 400 && !got; k++) begin
            @(negedge SCLK);
            drive_lanes(v, k);
            if (k == 0) lane_mask = ~v.mask;
            @(posedge SCLK);
            #1;
            lat++;
            if (dfi_rdlvl_resp) got = 1;
        end
        chk({nm, " resp_seen"}, 32'(got), 32'd1);
        chk({nm, " latency"}, lat, v.lat);
        chk({nm, " train_cycles"}, train_cycles, v.tc);
        chk({nm, " timeout"}, rdlvl_timeout, v.to);
        chk({nm, " error"}, rdlvl_error, v.er);
        chk({nm, " done_status"}, lane_done_status, v.dn);
        chk({nm, " err_status"}, lane_err_status, v.es);
        chk({nm, " gate_mode"}, rdlvl_gate_mode, v.gate);
        @(negedge SCLK);
        dfi_rdlvl_resp_internal = '1;
        rd_training_error       = '1;
        @(posedge SCLK);
        #1;
        chk({nm, " resp_hold"}, dfi_rdlvl_resp, 1'b1);
        chk({nm, " done_frozen"}, lane_done_status, v.dn);
        chk({nm, " err_frozen"}, lane_err_status, v.es);
        @(negedge SCLK);
        dfi_rdlvl_en            = 1'b0;
        dfi_rdlvl_gate_en       = 1'b0;
        dfi_rdlvl_resp_internal = '0;
        rd_training_error       = '0;
        @(posedge SCLK);
        #1;
        chk({nm, " resp_drop"}, dfi_rdlvl_resp, 1'b0);
        @(posedge SCLK);
    endtask

    vec_t tv[8];

    initial begin
        vec_t v;
        bit   seen;

        for (int r = 0; r < 8; r++) begin
            tv[r].mask = 9'h1FF; tv[r].tmo = 16'd0; tv[r].gate = 1'b0;
            tv[r].done_at = stair(); tv[r].err_at = all_at(NEVER);
            tv[r].to = 1'b0; tv[r].er = 1'b0; tv[r].es = 9'h000; tv[r].dn = 9'h1FF;
        end
        tv[0].lat = 9; tv[0].tc = 9;
        tv[1].mask = 9'h0FF; tv[1].done_at[8] = NEVER; tv[1].err_at[3] = 8'd5;
        tv[1].lat = 8; tv[1].tc = 8; tv[1].er = 1'b1; tv[1].dn = 9'h0FF; tv[1].es = 9'h008;
        tv[2].tmo = 16'd100; tv[2].done_at[2] = NEVER;
        tv[2].lat = 100; tv[2].tc = 100; tv[2].to = 1'b1; tv[2].dn = 9'h1FB;
        tv[3].tmo = 16'd50; tv[3].done_at = all_at(8'd0); tv[3].done_at[4] = 8'd49;
        tv[3].lat = 50; tv[3].tc = 50;
        tv[4].mask = 9'h000; tv[4].done_at = all_at(NEVER); tv[4].err_at[0] = 8'd0;
        tv[4].lat = 1; tv[4].tc = 1; tv[4].dn = 9'h000; tv[4].es = 9'h001;
        tv[5].tmo = 16'd1; tv[5].done_at = all_at(NEVER);
        tv[5].lat = 1; tv[5].tc = 1; tv[5].to = 1'b1; tv[5].dn = 9'h000;
        tv[6].gate = 1'b1; tv[6].mask = 9'h005; tv[6].done_at = all_at(NEVER);
        tv[6].done_at[0] = 8'd3; tv[6].done_at[2] = 8'd6; tv[6].err_at[1] = 8'd2;
        tv[6].lat = 7; tv[6].tc = 7; tv[6].dn = 9'h005; tv[6].es = 9'h002;
        tv[7].done_at = all_at(8'd0); tv[7].err_at[5] = 8'd1;
        tv[7].lat = 1; tv[7].tc = 1;

        // Reset: outputs cleared without any clock edge, request ignored.
        #1 reset_n = 1'b0;
        dfi_rdlvl_en = 1'b1;
        #2;
        chk("reset resp", dfi_rdlvl_resp, 1'b0);
        chk("reset status", {lane_done_status, lane_err_status}, 18'h0);
        chk("reset flags", {rdlvl_error, rdlvl_timeout, rdlvl_gate_mode}, 3'b000);
        chk("reset train_cycles", train_cycles, 16'h0);
        repeat (3) @(posedge SCLK);
        #1 chk("reset held resp", dfi_rdlvl_resp, 1'b0);
        @(negedge SCLK);
        dfi_rdlvl_en = 1'b0;
        reset_n = 1'b1;
        @(posedge SCLK);

        for (int r = 0; r < 8; r++) run_ep(tv[r], $sformatf("vec%0d", r));

        for (int n = 0; n < 20; n++) begin
            v.mask = 9'($urandom_range(0, 511));
            v.gate = 1'($urandom_range(0, 1));
            v.tmo  = ($urandom_range(0, 2) == 0) ? 16'd0 : 16'($urandom_range(1, 40));
            for (int i = 0; i < LANES; i++) begin
                v.done_at[i] = (v.tmo != 0 && $urandom_range(0, 4) == 0) ? NEVER : 8'($urandom_range(0, 30));
                v.err_at[i]  = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(0, 35)) : NEVER;
            end
            run_ep(model(v), $sformatf("rnd%0d", n));
        end

        // Abort: gate training dropped in its fifth cycle.
        @(negedge SCLK);
        dfi_rdlvl_gate_en = 1'b1; lane_mask = 9'h1FF; timeout_cycles = 16'd0;
        @(posedge SCLK);
        for (int k = 0; k < 4; k++) begin
            @(negedge SCLK);
            dfi_rdlvl_resp_internal = (k >= 1) ? 9'h002 : 9'h000;
            @(posedge SCLK);
        end
        @(negedge SCLK);
        dfi_rdlvl_gate_en = 1'b0;
        dfi_rdlvl_resp_internal = '0;
        seen = 0;
        repeat (8) begin
            @(posedge SCLK);
            #1 if (dfi_rdlvl_resp) seen = 1;
        end
        chk("abort no_resp", 32'(seen), 32'd0);
        chk("abort gate_mode", rdlvl_gate_mode, 1'b1);
        chk("abort done_kept", lane_done_status, 9'h002);
        run_ep(tv[0], "after_abort");

        // Request pulsed low for one cycle in RESP: restart after dead cycle.
        @(negedge SCLK);
        dfi_rdlvl_en = 1'b1; lane_mask = 9'h000;
        @(posedge SCLK);
        @(posedge SCLK);
        #1 chk("absorb resp1", dfi_rdlvl_resp, 1'b1);
        @(negedge SCLK) dfi_rdlvl_en = 1'b0;
        @(posedge SCLK);
        #1 chk("absorb wait", dfi_rdlvl_resp, 1'b0);
        @(negedge SCLK) dfi_rdlvl_en = 1'b1;
        @(posedge SCLK);
        #1 chk("absorb idle", dfi_rdlvl_resp, 1'b0);
        @(posedge SCLK);
        #1 chk("absorb train", dfi_rdlvl_resp, 1'b0);
        @(posedge SCLK);
        #1 chk("absorb resp2", dfi_rdlvl_resp, 1'b1);
        @(negedge SCLK) dfi_rdlvl_en = 1'b0;
        repeat (2) @(posedge SCLK);

        // Reset asserted while in RESP.
        @(negedge SCLK);
        dfi_rdlvl_gate_en = 1'b1; lane_mask = 9'h000;
        @(posedge SCLK);
        @(negedge SCLK) dfi_rdlvl_resp_internal = 9'h001;
        @(posedge SCLK);
        #1;
        chk("rst_resp pre resp", dfi_rdlvl_resp, 1'b1);
        chk("rst_resp pre done", lane_done_status, 9'h001);
        #2 reset_n = 1'b0;
        #1;
        chk("rst_resp resp", dfi_rdlvl_resp, 1'b0);
        chk("rst_resp status", {lane_done_status, lane_err_status}, 18'h0);
        chk("rst_resp flags", {rdlvl_gate_mode, rdlvl_error, rdlvl_timeout}, 3'b000);
        chk("rst_resp train_cycles", train_cycles, 16'h0);
        dfi_rdlvl_gate_en = 1'b0;
        dfi_rdlvl_resp_internal = '0;
        @(negedge SCLK) reset_n = 1'b1;
        seen = 0;
        repeat (4) begin
            @(posedge SCLK);
            #1 if (dfi_rdlvl_resp) seen = 1;
        end
        chk("rst_resp no_restart", 32'(seen), 32'd0);
        run_ep(tv[1], "after_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
